// File: rtl/bus_wait_pkg.sv
// rtl/bus_wait_pkg.sv - shared types and constants for the XT bus wait-state sequencer
package bus_wait_pkg;

  typedef enum logic [1:0] {IDLE, COUNT, EXTWAIT, DONE} wait_state_t;
  typedef enum logic [1:0] {CLS_IO, CLS_MEM, CLS_VIDEO} bus_class_t;

  localparam logic [2:0] VIDEO_REGION = 3'b101;

  localparam logic [1:0] CFG_SEL_IO    = 2'd0;
  localparam logic [1:0] CFG_SEL_MEM   = 2'd1;
  localparam logic [1:0] CFG_SEL_VIDEO = 2'd2;
  localparam logic [1:0] CFG_SEL_CLEAR = 2'd3;

  // An I/O strobe takes precedence over a concurrent memory strobe.
  function automatic bus_class_t classify(input logic io_cmd, input logic [2:0] region);
    if (io_cmd)
      return CLS_IO;
    else if (region == VIDEO_REGION)
      return CLS_VIDEO;
    else
      return CLS_MEM;
  endfunction

endpackage

// File: rtl/cpu_clock_edge.sv
// rtl/cpu_clock_edge.sv - cpu_clock level sampled on the system clock, one-clock edge pulses
module cpu_clock_edge (
  input  logic clock,
  input  logic reset,
  input  logic cpu_clock,
  output logic rise,
  output logic fall
);

  logic prev_cpu_clock;

  always_ff @(posedge clock) begin
    if (reset)
      prev_cpu_clock <= 1'b0;
    else
      prev_cpu_clock <= cpu_clock;
  end

  assign rise = ~prev_cpu_clock & cpu_clock;
  assign fall = prev_cpu_clock & ~cpu_clock;

endmodule

// File: rtl/bus_wait_state_sequencer.sv
// rtl/bus_wait_state_sequencer.sv - per-class wait states, external ready extension and bus watchdog
module bus_wait_state_sequencer
  import bus_wait_pkg::*;
#(
  parameter int NUM_EXT        = 2,
  parameter int IO_WAIT_RST    = 1,
  parameter int MEM_WAIT_RST   = 0,
  parameter int VIDEO_WAIT_RST = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               cpu_clock,
  input  logic               io_read_n,
  input  logic               io_write_n,
  input  logic               memory_read_n,
  input  logic               memory_write_n,
  input  logic               address_enable_n,
  input  logic [19:0]        address,
  input  logic [NUM_EXT-1:0] ext_ready_n,
  input  logic               cfg_write,
  input  logic [1:0]         cfg_select,
  input  logic [3:0]         cfg_data,
  output logic               io_channel_ready,
  output logic               bus_timeout,
  output logic               timeout_status
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  wait_state_t   state, state_next;
  bus_class_t    start_class;
  logic [3:0]    io_wait, mem_wait, video_wait;
  logic [3:0]    count, start_wait;
  logic [TW-1:0] timer;
  logic          io_cmd, mem_cmd, command, prev_command, start;
  logic          ext_clear, cpu_rise, cpu_fall;
  logic          timeout_fire, ready_next;

  cpu_clock_edge u_cpu_clock_edge (
    .clock     (clock),
    .reset     (reset),
    .cpu_clock (cpu_clock),
    .rise      (cpu_rise),
    .fall      (cpu_fall)
  );

  // DMA memory cycles (address_enable_n low) are not CPU cycles and are ignored.
  assign io_cmd    = ~io_read_n | ~io_write_n;
  assign mem_cmd   = address_enable_n & (~memory_read_n | ~memory_write_n);
  assign command   = io_cmd | mem_cmd;
  assign start     = command & ~prev_command;
  assign ext_clear = &ext_ready_n;

  assign start_class = classify(io_cmd, address[19:17]);

  always_comb begin
    start_wait = mem_wait;
    case (start_class)
      CLS_IO:    start_wait = io_wait;
      CLS_VIDEO: start_wait = video_wait;
      default:   start_wait = mem_wait;
    endcase
  end

  always_comb begin
    state_next   = state;
    timeout_fire = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (start_wait != 4'd0)
            state_next = COUNT;
          else if (!ext_clear)
            state_next = EXTWAIT;
          else
            state_next = DONE;
        end
      end
      COUNT: begin
        if (!command)
          state_next = IDLE;
        else if (cpu_rise && count == 4'd1)
          state_next = EXTWAIT;
      end
      EXTWAIT: begin
        // A peripheral releasing on the watchdog's final edge wins over the timeout.
        if (!command)
          state_next = IDLE;
        else if (ext_clear)
          state_next = DONE;
        else if (cpu_rise && timer == TIMER_LAST) begin
          state_next   = DONE;
          timeout_fire = 1'b1;
        end
      end
      DONE: begin
        if (!command)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Ready is registered from the next state so it moves one clock after each decision.
  always_comb begin
    ready_next = 1'b1;
    case (state_next)
      COUNT:   ready_next = 1'b0;
      EXTWAIT: ready_next = ext_clear;
      default: ready_next = 1'b1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state            <= IDLE;
      io_channel_ready <= 1'b1;
      bus_timeout      <= 1'b0;
      prev_command     <= 1'b0;
    end else begin
      state            <= state_next;
      io_channel_ready <= ready_next;
      bus_timeout      <= timeout_fire;
      prev_command     <= command;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= 4'd0;
      timer <= '0;
    end else begin
      if (state == IDLE && start)
        count <= start_wait;
      else if (state == COUNT && cpu_rise)
        count <= count - 4'd1;

      if (state_next == EXTWAIT && state != EXTWAIT)
        timer <= '0;
      else if (state == EXTWAIT && cpu_rise)
        timer <= timer + 1'b1;
    end
  end

  // Count is latched from the old register value, so a same-clock write only affects later cycles.
  always_ff @(posedge clock) begin
    if (reset) begin
      io_wait        <= 4'(IO_WAIT_RST);
      mem_wait       <= 4'(MEM_WAIT_RST);
      video_wait     <= 4'(VIDEO_WAIT_RST);
      timeout_status <= 1'b0;
    end else begin
      if (cfg_write) begin
        case (cfg_select)
          CFG_SEL_IO:    io_wait    <= cfg_data;
          CFG_SEL_MEM:   mem_wait   <= cfg_data;
          CFG_SEL_VIDEO: video_wait <= cfg_data;
          default:       ;
        endcase
      end
      if (timeout_fire)
        timeout_status <= 1'b1;
      else if (cfg_write && cfg_select == CFG_SEL_CLEAR)
        timeout_status <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bus_wait_state_sequencer.sv
// tb/tb_bus_wait_state_sequencer.sv - directed vector table, corner sequences and randomized transactions
module tb_bus_wait_state_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        cpu_clock;
  logic        io_read_n, io_write_n, memory_read_n, memory_write_n, address_enable_n;
  logic [19:0] address;
  logic [1:0]  ext_ready_n;
  logic        cfg_write;
  logic [1:0]  cfg_select;
  logic [3:0]  cfg_data;
  logic        io_channel_ready, bus_timeout, timeout_status;

  int n_checks = 0;
  int n_pass   = 0;

  int m_io  = 1;
  int m_mem = 0;
  int m_vid = 4;
  bit m_st  = 1'b0;

  always #5 clock = ~clock;

  bus_wait_state_sequencer dut (
    .clock            (clock),
    .reset            (reset),
    .cpu_clock        (cpu_clock),
    .io_read_n        (io_read_n),
    .io_write_n       (io_write_n),
    .memory_read_n    (memory_read_n),
    .memory_write_n   (memory_write_n),
    .address_enable_n (address_enable_n),
    .address          (address),
    .ext_ready_n      (ext_ready_n),
    .cfg_write        (cfg_write),
    .cfg_select       (cfg_select),
    .cfg_data         (cfg_data),
    .io_channel_ready (io_channel_ready),
    .bus_timeout      (bus_timeout),
    .timeout_status   (timeout_status)
  );

  typedef struct {
    string       name;
    logic [3:0]  stb;
    logic        aen;
    logic [19:0] addr;
    logic [1:0]  ext;
    int          rel;
    int          len;
    logic        cfg_we;
    logic [3:0]  cfg_dat;
    int          exp_d;
    int          exp_to;
    bit          exp_st;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp)
      n_pass++;
    else
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
  endtask

  function automatic logic pat(input int k, input int hh, input int ph);
    int m;
    m = (k + ph + 1200) % (2 * hh);
    return m >= hh;
  endfunction

  function automatic bit rise(input int k, input int hh, input int ph);
    return pat(k, hh, ph) && !pat(k - 1, hh, ph);
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // stb bits: {io_read, io_write, memory_read, memory_write}, 1 = asserted
  task automatic drive(input logic [3:0] stb, input logic aen, input logic [19:0] addr,
                       input logic [1:0] ext_low);
    io_read_n        = ~stb[3];
    io_write_n       = ~stb[2];
    memory_read_n    = ~stb[1];
    memory_write_n   = ~stb[0];
    address_enable_n = aen;
    address          = addr;
    ext_ready_n      = ~ext_low;
  endtask

  // Edge k is the clock edge that first sees the strobe; ready must read low for k < exp_d.
  task automatic txn(input string name, input int hh, input int ph, input logic [3:0] stb,
                     input logic aen, input logic [19:0] addr, input logic [1:0] ext_mask,
                     input int rel, input int cmd_len, input logic cfg_we, input logic [1:0] csel,
                     input logic [3:0] cdat, input int exp_d, input int exp_to, input bit exp_st);
    for (int k = -3; k < 0; k++) begin
      drive(4'b0000, 1'b1, 20'h0, 2'b00);
      cpu_clock = pat(k, hh, ph);
      cfg_write = 1'b0;
      step();
      check($sformatf("%s/idle_ready@%0d", name, k), io_channel_ready, 1);
    end
    for (int k = 0; k < cmd_len + 3; k++) begin
      drive((k < cmd_len) ? stb : 4'b0000, aen, addr, (rel < 0 || k < rel) ? ext_mask : 2'b00);
      cpu_clock  = pat(k, hh, ph);
      cfg_write  = cfg_we && (k == 0);
      cfg_select = csel;
      cfg_data   = cdat;
      step();
      check($sformatf("%s/ready@%0d", name, k), io_channel_ready, (k < exp_d) ? 0 : 1);
      check($sformatf("%s/timeout@%0d", name, k), bus_timeout, (k == exp_to) ? 1 : 0);
    end
    cfg_write = 1'b0;
    check($sformatf("%s/status", name), timeout_status, exp_st);
  endtask

  task automatic random_txn(input int t);
    logic [3:0]  stb;
    logic        aen, cwe;
    logic [19:0] addr;
    logic [1:0]  em, cs;
    logic [3:0]  cd;
    int          rel, rel_eff, hh, ph, n, p, q, d, to, len, cnt;
    bit          io, cmd;

    case ($urandom % 5)
      0: stb = 4'b1000;
      1: stb = 4'b0100;
      2: stb = 4'b0010;
      3: stb = 4'b0001;
      default: stb = 4'b1010;
    endcase
    aen  = ($urandom % 6) != 0;
    addr = 20'($urandom);
    if ($urandom % 2 == 1) addr[19:17] = 3'b101;
    em   = 2'($urandom);
    rel  = ($urandom % 10 == 0) ? -1 : int'($urandom % 40);
    hh   = 1 + int'($urandom % 3);
    ph   = int'($urandom % 6);
    cwe  = ($urandom % 4) == 0;
    cs   = 2'($urandom);
    cd   = 4'($urandom);

    io  = stb[3] | stb[2];
    cmd = io | (aen & (stb[1] | stb[0]));
    n   = io ? m_io : ((addr[19:17] == 3'b101) ? m_vid : m_mem);
    if (cwe) begin
      case (cs)
        2'd0: m_io  = cd;
        2'd1: m_mem = cd;
        2'd2: m_vid = cd;
        default: m_st = 1'b0;
      endcase
    end

    // p: edge of the n-th cpu_clock rise after start; q: 64th rise after that.
    p = 0;
    cnt = 0;
    for (int k = 1; cnt < n; k++) begin
      if (rise(k, hh, ph)) begin
        cnt++;
        p = k;
      end
    end
    q = p;
    cnt = 0;
    while (cnt < 64) begin
      q++;
      if (rise(q, hh, ph)) cnt++;
    end
    rel_eff = (em == 2'b00) ? 0 : ((rel < 0) ? (1 << 30) : rel);
    if (rel_eff > q) begin
      d  = q;
      to = q;
    end else begin
      d  = (p > rel_eff) ? p : rel_eff;
      to = -1;
    end
    if (!cmd) begin
      d  = 0;
      to = -1;
    end
    len = d + 1 + int'($urandom % 4);
    if (cmd && d > 0 && ($urandom % 5) == 0) begin
      len = 1 + int'($urandom % d);
      if (to >= len) to = -1;
      if (len < d) d = len;
    end
    if (to >= 0) m_st = 1'b1;

    txn($sformatf("rnd%0d", t), hh, ph, stb, aen, addr, em, rel, len, cwe, cs, cd, d, to, m_st);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    // name, stb, aen, addr, ext, rel, len(0=auto), cfg_we, cfg_dat, exp_d, exp_to, exp_st
    tbl.push_back('{"io_rd",     4'b1000, 1'b1, 20'h00000, 2'b00,   0,  0, 1'b0, 4'd0,   2,  -1, 1'b0});
    tbl.push_back('{"io_wr",     4'b0100, 1'b1, 20'h00000, 2'b00,   0,  0, 1'b0, 4'd0,   2,  -1, 1'b0});
    tbl.push_back('{"vid_rd",    4'b0010, 1'b1, 20'hB8000, 2'b00,   0,  0, 1'b0, 4'd0,  14,  -1, 1'b0});
    tbl.push_back('{"mem_rd",    4'b0010, 1'b1, 20'h10000, 2'b00,   0,  0, 1'b0, 4'd0,   0,  -1, 1'b0});
    tbl.push_back('{"vid_wr",    4'b0001, 1'b1, 20'hA0000, 2'b00,   0,  0, 1'b0, 4'd0,  14,  -1, 1'b0});
    tbl.push_back('{"dma_wr",    4'b0001, 1'b0, 20'hB8000, 2'b00,   0,  0, 1'b0, 4'd0,   0,  -1, 1'b0});
    tbl.push_back('{"mem_c0000", 4'b0010, 1'b1, 20'hC0000, 2'b00,   0,  0, 1'b0, 4'd0,   0,  -1, 1'b0});
    tbl.push_back('{"mem_9ffff", 4'b0010, 1'b1, 20'h9FFFF, 2'b00,   0,  0, 1'b0, 4'd0,   0,  -1, 1'b0});
    tbl.push_back('{"ext1_hold", 4'b1000, 1'b1, 20'h00000, 2'b10,  42,  0, 1'b0, 4'd0,  42,  -1, 1'b0});
    tbl.push_back('{"ext0_n0",   4'b0010, 1'b1, 20'h10000, 2'b01,   5,  0, 1'b0, 4'd0,   5,  -1, 1'b0});
    tbl.push_back('{"io_wins",   4'b1010, 1'b1, 20'hB8000, 2'b00,   0,  0, 1'b0, 4'd0,   2,  -1, 1'b0});
    tbl.push_back('{"abort_cnt", 4'b0010, 1'b1, 20'hB8000, 2'b00,   0,  6, 1'b0, 4'd0,   6,  -1, 1'b0});
    tbl.push_back('{"abort_ext", 4'b1000, 1'b1, 20'h00000, 2'b01,  -1, 20, 1'b0, 4'd0,  20,  -1, 1'b0});
    tbl.push_back('{"timeout",   4'b1000, 1'b1, 20'h00000, 2'b01,  -1,  0, 1'b0, 4'd0, 258, 258, 1'b1});
    tbl.push_back('{"ext_vs_to", 4'b1000, 1'b1, 20'h00000, 2'b01, 258,  0, 1'b0, 4'd0, 258,  -1, 1'b1});
    tbl.push_back('{"cfg_same",  4'b1000, 1'b1, 20'h00000, 2'b00,   0,  0, 1'b1, 4'd7,   2,  -1, 1'b1});
    tbl.push_back('{"io7",       4'b1000, 1'b1, 20'h00000, 2'b00,   0,  0, 1'b0, 4'd0,  26,  -1, 1'b1});

    reset     = 1'b1;
    cpu_clock = 1'b0;
    cfg_write = 1'b0;
    cfg_select = 2'd0;
    cfg_data  = 4'd0;
    drive(4'b0000, 1'b1, 20'h0, 2'b00);
    for (int i = 0; i < 3; i++) step();
    check("reset/ready", io_channel_ready, 1);
    check("reset/timeout", bus_timeout, 0);
    check("reset/status", timeout_status, 0);
    reset = 1'b0;

    foreach (tbl[i]) begin
      txn(tbl[i].name, 2, 0, tbl[i].stb, tbl[i].aen, tbl[i].addr, tbl[i].ext, tbl[i].rel,
          (tbl[i].len == 0) ? tbl[i].exp_d + 2 : tbl[i].len, tbl[i].cfg_we, 2'd0,
          tbl[i].cfg_dat, tbl[i].exp_d, tbl[i].exp_to, tbl[i].exp_st);
    end

    // Reset while a video cycle sits in COUNT with the strobe still held.
    for (int k = -3; k < 0; k++) begin
      drive(4'b0000, 1'b1, 20'h0, 2'b00);
      cpu_clock = pat(k, 2, 0);
      step();
    end
    for (int k = 0; k < 5; k++) begin
      drive(4'b0010, 1'b1, 20'hB8000, 2'b00);
      cpu_clock = pat(k, 2, 0);
      step();
      check($sformatf("rst_mid/ready_low@%0d", k), io_channel_ready, 0);
    end
    reset = 1'b1;
    cpu_clock = pat(5, 2, 0);
    step();
    check("rst_mid/ready", io_channel_ready, 1);
    check("rst_mid/timeout", bus_timeout, 0);
    check("rst_mid/status", timeout_status, 0);
    reset = 1'b0;
    drive(4'b0000, 1'b1, 20'h0, 2'b00);
    step();
    check("rst_mid/ready_after", io_channel_ready, 1);
    m_io  = 1;
    m_mem = 0;
    m_vid = 4;
    m_st  = 1'b0;

    txn("io_after_rst", 2, 0, 4'b1000, 1'b1, 20'h0, 2'b00, 0, 4, 1'b0, 2'd0, 4'd0, 2, -1, 1'b0);
    txn("timeout2", 2, 0, 4'b1000, 1'b1, 20'h0, 2'b01, -1, 260, 1'b0, 2'd0, 4'd0, 258, 258, 1'b1);
    cfg_write  = 1'b1;
    cfg_select = 2'd3;
    step();
    cfg_write = 1'b0;
    check("cfg_clear/status", timeout_status, 0);

    for (int t = 0; t < 40; t++) random_txn(t);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
